fg_prog_sequencer: RTL and testbench
====================================

// Module: fg_prog_sequencer
// PURPOSE
//   Multi-island floating-gate programming sequencer for the CAB fabric. Takes one
//   command at a time and drives the per-island programming mux:
//     - VinjDecode row/column addresses
//     - decoder enable
//     - prog_r / run_r
//     - tunnel enable
//   Each command runs as a timed, break-before-make sequence so that no drain or gate
//   switches while a prog pulse is active. It generalises the fixed single-island mux
//   control to ISLANDS islands, parametrised address widths and programmable pulse
//   lengths, and adds abort and error handling.
// PARAMETERS
//   ISLANDS     2   number of islands; island_sel is one-hot over these
//   ISL_BITS    1   width of cmd_island; must satisfy 2**ISL_BITS >= ISLANDS
//   ROW_BITS    6   vertical decoder address width
//   COL_BITS    6   horizontal decoder address width
//   PW_BITS     16  pulse-length counter width
//   SETTLE_CYC  8   settle cycles for each of ADDR, ARM and RECOVER; must be >= 1
// PORTS
//   clk          in   1          system clock
//   reset        in   1          asynchronous reset, active high
//   cmd_valid    in   1          command present
//   cmd_ready    out  1          sequencer can accept a command (high only in IDLE)
//   cmd_op       in   2          00 RUN, 01 INJECT, 10 TUNNEL, 11 READ
//   cmd_island   in   ISL_BITS   target island
//   cmd_row      in   ROW_BITS   target row
//   cmd_col      in   COL_BITS   target column
//   cmd_pulse    in   PW_BITS    pulse/measure window length in cycles
//   abort        in   1          request to terminate the current command safely
//   island_sel   out  ISLANDS    one-hot island select to the programming mux
//   row_addr     out  ROW_BITS   registered row address
//   col_addr     out  COL_BITS   registered column address
//   dec_en       out  1          decoder enable
//   prog_r       out  1          injection pulse
//   vtun_en      out  1          tunnel pulse
//   run_r        out  1          fabric in run mode
//   meas_strobe  out  1          one-cycle sample request for READ
//   done         out  1          one-cycle completion pulse
//   err          out  1          valid only in the same cycle as done
// BEHAVIOUR
//   Reset
//     - Asynchronous. All outputs go to 0 except cmd_ready=1 and run_r=1.
//     - State goes to IDLE and all counters clear.
//     - prog_r and vtun_en drop the moment reset asserts, mid-pulse included.
//   Handshake
//     - A command is accepted on a clock edge where cmd_valid && cmd_ready.
//     - Command fields are latched on that edge. cmd_ready goes low on the next cycle.
//   Op RUN
//     - IDLE -> DONE.
//     - run_r=1; done is asserted one cycle after accept.
//   Ops INJECT / TUNNEL / READ
//     - IDLE -> ADDR -> ARM -> PULSE -> RECOVER -> DONE -> IDLE.
//     - On accept: run_r <= 0. row_addr, col_addr and island_sel update.
//       For TUNNEL, row_addr and col_addr are held at 0.
//     - ADDR (SETTLE_CYC cycles): addresses stable, dec_en=0.
//     - ARM (SETTLE_CYC cycles): dec_en=1 for INJECT and READ; dec_en stays 0 for TUNNEL.
//     - PULSE (exactly cmd_pulse cycles):
//         INJECT: prog_r=1
//         TUNNEL: vtun_en=1
//         READ:   no pulse; meas_strobe=1 in the last PULSE cycle
//     - RECOVER (SETTLE_CYC cycles): prog_r, vtun_en and dec_en are 0. Addresses are held.
//     - DONE (1 cycle): done=1, run_r <= 1, island_sel <= 0. Then IDLE with cmd_ready=1.
//     - Latency from the accept edge to the done cycle = 3*SETTLE_CYC + cmd_pulse + 1 cycles.
//   Errors (err=1 with done)
//     - cmd_island >= ISLANDS, or cmd_pulse==0 on a non-RUN op:
//       go directly IDLE -> DONE; no output other than done/err changes.
//     - abort in ADDR, ARM or PULSE: next state is RECOVER with pulses deasserted that
//       cycle. RECOVER runs its full length, then DONE with err=1.
//     - abort in RECOVER, DONE or IDLE is ignored.
//   Invariants
//     - prog_r and vtun_en are never both 1.
//     - dec_en never toggles in the same cycle that the address changes.
//     - Counters count down from their load value to 1. There is no wrap:
//       cmd_pulse = 2**PW_BITS-1 is a legal maximum.
// TESTING (SETTLE_CYC=4 unless noted)
//   1. INJECT, island 1, row 5, col 9, pulse 10
//      -> prog_r high exactly 10 cycles; dec_en high 14 cycles;
//         done 23 cycles after accept; err=0; island_sel=2'b10 during the op.
//   2. TUNNEL, pulse 3
//      -> vtun_en high 3 cycles; dec_en, prog_r and row/col stay 0; done at +16.
//   3. READ, pulse 1
//      -> meas_strobe in the single PULSE cycle; prog_r never 1; done at +14.
//   4. INJECT with pulse 100; abort on the 5th PULSE cycle
//      -> prog_r low the next cycle; 4 RECOVER cycles; done with err=1.
//   5. cmd_island=3 with ISLANDS=2, and separately pulse=0
//      -> done+err 1 cycle after accept; run_r stays 1; dec_en stays 0.
//   6. Async reset asserted mid-PULSE, between clock edges
//      -> prog_r and dec_en go to 0 immediately; cmd_ready=1 and run_r=1 after release.

Source files
------------

// File: rtl/fg_prog_sequencer.sv
// Multi-island floating-gate programming sequencer: accepts one command at a time and
// drives the programming mux through a timed, break-before-make address/arm/pulse/recover sequence.
module fg_prog_sequencer #(
  parameter int ISLANDS    = 2,
  parameter int ISL_BITS   = 1,
  parameter int ROW_BITS   = 6,
  parameter int COL_BITS   = 6,
  parameter int PW_BITS    = 16,
  parameter int SETTLE_CYC = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [ISL_BITS-1:0] cmd_island,
  input  logic [ROW_BITS-1:0] cmd_row,
  input  logic [COL_BITS-1:0] cmd_col,
  input  logic [PW_BITS-1:0]  cmd_pulse,
  input  logic                abort,
  output logic [ISLANDS-1:0]  island_sel,
  output logic [ROW_BITS-1:0] row_addr,
  output logic [COL_BITS-1:0] col_addr,
  output logic                dec_en,
  output logic                prog_r,
  output logic                vtun_en,
  output logic                run_r,
  output logic                meas_strobe,
  output logic                done,
  output logic                err
);

  localparam int ST_BITS = $clog2(SETTLE_CYC + 1);
  localparam logic [ST_BITS-1:0] SETTLE_LD = ST_BITS'(SETTLE_CYC);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ARM, S_PULSE, S_RECOVER, S_DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_RUN  = 2'b00,
    OP_INJ  = 2'b01,
    OP_TUN  = 2'b10,
    OP_READ = 2'b11
  } op_e;

  state_e              state_q, state_d;
  op_e                 op_q, op_d, op_in;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [COL_BITS-1:0] col_q, col_d;
  logic [ISLANDS-1:0]  isl_q, isl_d;
  logic                run_q, run_d;
  logic                err_q, err_d;
  logic [ST_BITS-1:0]  st_q, st_d;
  logic [PW_BITS-1:0]  pw_q, pw_d;
  logic                bad_island;
  logic                bad_pulse;

  assign op_in      = op_e'(cmd_op);
  assign bad_island = 32'(cmd_island) >= 32'(ISLANDS);
  assign bad_pulse  = (op_in != OP_RUN) && (cmd_pulse == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_RUN;
      row_q   <= '0;
      col_q   <= '0;
      isl_q   <= '0;
      run_q   <= 1'b1;
      err_q   <= 1'b0;
      st_q    <= '0;
      pw_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      row_q   <= row_d;
      col_q   <= col_d;
      isl_q   <= isl_d;
      run_q   <= run_d;
      err_q   <= err_d;
      st_q    <= st_d;
      pw_q    <= pw_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    row_d   = row_q;
    col_d   = col_q;
    isl_d   = isl_q;
    run_d   = run_q;
    err_d   = err_q;
    st_d    = st_q;
    pw_d    = pw_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d  = op_in;
          err_d = 1'b0;
          // Rejected commands touch nothing but done/err.
          if (bad_island || bad_pulse) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (op_in == OP_RUN) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ADDR;
            run_d   = 1'b0;
            isl_d   = ISLANDS'(1) << cmd_island;
            row_d   = (op_in == OP_TUN) ? '0 : cmd_row;
            col_d   = (op_in == OP_TUN) ? '0 : cmd_col;
            st_d    = SETTLE_LD;
            pw_d    = cmd_pulse;
          end
        end
      end
      S_ADDR: begin
        if (abort) begin
          state_d = S_RECOVER;
          st_d    = SETTLE_LD;
          err_d   = 1'b1;
        end else if (st_q == ST_BITS'(1)) begin
          state_d = S_ARM;
          st_d    = SETTLE_LD;
        end else begin
          st_d = st_q - ST_BITS'(1);
        end
      end
      S_ARM: begin
        if (abort) begin
          state_d = S_RECOVER;
          st_d    = SETTLE_LD;
          err_d   = 1'b1;
        end else if (st_q == ST_BITS'(1)) begin
          state_d = S_PULSE;
        end else begin
          st_d = st_q - ST_BITS'(1);
        end
      end
      S_PULSE: begin
        if (abort) begin
          state_d = S_RECOVER;
          st_d    = SETTLE_LD;
          err_d   = 1'b1;
        end else if (pw_q == PW_BITS'(1)) begin
          state_d = S_RECOVER;
          st_d    = SETTLE_LD;
        end else begin
          pw_d = pw_q - PW_BITS'(1);
        end
      end
      S_RECOVER: begin
        if (st_q == ST_BITS'(1)) begin
          state_d = S_DONE;
          run_d   = 1'b1;
          isl_d   = '0;
        end else begin
          st_d = st_q - ST_BITS'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Drive outputs are pure state decodes so an async reset clears them without a clock.
  always_comb begin
    cmd_ready   = (state_q == S_IDLE);
    island_sel  = isl_q;
    row_addr    = row_q;
    col_addr    = col_q;
    run_r       = run_q;
    dec_en      = ((state_q == S_ARM) || (state_q == S_PULSE)) && (op_q != OP_TUN);
    prog_r      = (state_q == S_PULSE) && (op_q == OP_INJ);
    vtun_en     = (state_q == S_PULSE) && (op_q == OP_TUN);
    meas_strobe = (state_q == S_PULSE) && (op_q == OP_READ) && (pw_q == PW_BITS'(1));
    done        = (state_q == S_DONE);
    err         = (state_q == S_DONE) && err_q;
  end

endmodule

// File: tb/tb_fg_prog_sequencer.sv
// Directed self-checking bench for fg_prog_sequencer with SETTLE_CYC=4, two islands.
module tb_fg_prog_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [1:0]  cmd_island;
  logic [5:0]  cmd_row;
  logic [5:0]  cmd_col;
  logic [15:0] cmd_pulse;
  logic        abort;
  logic [1:0]  island_sel;
  logic [5:0]  row_addr;
  logic [5:0]  col_addr;
  logic        dec_en, prog_r, vtun_en, run_r, meas_strobe, done, err;

  int checks   = 0;
  int failures = 0;

  // Per-command observations
  int          lat, n_prog, n_vtun, n_dec, n_meas, meas_pos;
  logic        err_seen, both_seen, dec_addr_clash, ready_n1, run_all, run_any_low;
  logic [1:0]  isl_seen;
  logic [5:0]  row_or, col_or, row_seen, col_seen;

  fg_prog_sequencer #(
    .ISLANDS   (2),
    .ISL_BITS  (2),
    .ROW_BITS  (6),
    .COL_BITS  (6),
    .PW_BITS   (16),
    .SETTLE_CYC(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_island (cmd_island),
    .cmd_row    (cmd_row),
    .cmd_col    (cmd_col),
    .cmd_pulse  (cmd_pulse),
    .abort      (abort),
    .island_sel (island_sel),
    .row_addr   (row_addr),
    .col_addr   (col_addr),
    .dec_en     (dec_en),
    .prog_r     (prog_r),
    .vtun_en    (vtun_en),
    .run_r      (run_r),
    .meas_strobe(meas_strobe),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issues one command and watches it to completion; abort_n selects the cycle (1 = first after accept) to raise abort.
  task automatic run_cmd(input logic [1:0] op, input logic [1:0] isl, input logic [5:0] row,
                         input logic [5:0] col, input logic [15:0] pulse, input int abort_n);
    int   n;
    logic prev_dec;
    logic [5:0] prev_row;
    @(negedge clk);
    cmd_op = op; cmd_island = isl; cmd_row = row; cmd_col = col; cmd_pulse = pulse;
    cmd_valid = 1'b1;
    chk("ready_before_accept", cmd_ready, 1);
    prev_dec = dec_en; prev_row = row_addr;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    n = 1; lat = -1; n_prog = 0; n_vtun = 0; n_dec = 0; n_meas = 0; meas_pos = -1;
    err_seen = 1'b0; both_seen = 1'b0; dec_addr_clash = 1'b0; ready_n1 = 1'bx;
    run_all = 1'b1; run_any_low = 1'b0; isl_seen = '0; row_or = '0; col_or = '0;
    row_seen = '0; col_seen = '0;
    while (n < 2000) begin
      abort = (n == abort_n);
      @(negedge clk);
      if (n == 1) ready_n1 = cmd_ready;
      if (prog_r) n_prog++;
      if (vtun_en) n_vtun++;
      if (dec_en) n_dec++;
      if (meas_strobe) begin n_meas++; meas_pos = n; end
      if (prog_r && vtun_en) both_seen = 1'b1;
      if ((dec_en != prev_dec) && (row_addr != prev_row)) dec_addr_clash = 1'b1;
      prev_dec = dec_en; prev_row = row_addr;
      run_all = run_all & run_r;
      if (!run_r) run_any_low = 1'b1;
      row_or = row_or | row_addr;
      col_or = col_or | col_addr;
      if (prog_r || vtun_en || dec_en) begin
        isl_seen = island_sel; row_seen = row_addr; col_seen = col_addr;
      end
      if (done) begin
        lat = n; err_seen = err;
        break;
      end
      @(posedge clk);
      #1 n++;
    end
    abort = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; abort = 1'b0;
    cmd_op = '0; cmd_island = '0; cmd_row = '0; cmd_col = '0; cmd_pulse = '0;
    #22 reset = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_run_r", run_r, 1);
    chk("rst_dec_en", dec_en, 0);
    chk("rst_prog_r", prog_r, 0);
    chk("rst_done", done, 0);
    chk("rst_island_sel", island_sel, 0);

    // INJECT island 1, row 5, col 9, pulse 10
    run_cmd(2'b01, 2'd1, 6'd5, 6'd9, 16'd10, -1);
    chk("inj_latency", lat, 23);
    chk("inj_prog_cycles", n_prog, 10);
    chk("inj_dec_cycles", n_dec, 14);
    chk("inj_err", err_seen, 0);
    chk("inj_island_sel", isl_seen, 2'b10);
    chk("inj_row", row_seen, 5);
    chk("inj_col", col_seen, 9);
    chk("inj_vtun", n_vtun, 0);
    chk("inj_ready_busy", ready_n1, 0);
    chk("inj_run_low", run_any_low, 1);
    chk("inj_dec_addr_clash", dec_addr_clash, 0);
    @(negedge clk);
    chk("inj_post_run_r", run_r, 1);
    chk("inj_post_island_sel", island_sel, 0);
    chk("inj_post_ready", cmd_ready, 1);

    // TUNNEL island 0, nonzero row/col requested, pulse 3
    run_cmd(2'b10, 2'd0, 6'd7, 6'd3, 16'd3, -1);
    chk("tun_latency", lat, 16);
    chk("tun_vtun_cycles", n_vtun, 3);
    chk("tun_dec_cycles", n_dec, 0);
    chk("tun_prog_cycles", n_prog, 0);
    chk("tun_row_zero", row_or, 0);
    chk("tun_col_zero", col_or, 0);
    chk("tun_island_sel", isl_seen, 2'b01);
    chk("tun_err", err_seen, 0);

    // READ pulse 1: strobe in the single PULSE cycle (cycle 9)
    run_cmd(2'b11, 2'd0, 6'd1, 6'd2, 16'd1, -1);
    chk("read_latency", lat, 14);
    chk("read_meas_count", n_meas, 1);
    chk("read_meas_pos", meas_pos, 9);
    chk("read_prog", n_prog, 0);
    chk("read_dec_cycles", n_dec, 5);

    // INJECT pulse 100, abort during 5th PULSE cycle (cycle 13)
    run_cmd(2'b01, 2'd0, 6'd3, 6'd4, 16'd100, 13);
    chk("abort_prog_cycles", n_prog, 5);
    chk("abort_latency", lat, 18);
    chk("abort_err", err_seen, 1);
    chk("abort_both_pulses", both_seen, 0);

    // Bad island
    run_cmd(2'b01, 2'd3, 6'd8, 6'd8, 16'd5, -1);
    chk("badisl_latency", lat, 1);
    chk("badisl_err", err_seen, 1);
    chk("badisl_run_r", run_all, 1);
    chk("badisl_dec", n_dec, 0);
    chk("badisl_island_sel", isl_seen | island_sel, 0);
    chk("badisl_row_hold", row_or, 3);

    // Zero pulse on a non-RUN op
    run_cmd(2'b11, 2'd1, 6'd8, 6'd8, 16'd0, -1);
    chk("zpulse_latency", lat, 1);
    chk("zpulse_err", err_seen, 1);
    chk("zpulse_run_r", run_all, 1);
    chk("zpulse_dec", n_dec, 0);

    // RUN op, abort in IDLE must be ignored
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    run_cmd(2'b00, 2'd1, 6'd0, 6'd0, 16'd0, -1);
    chk("run_latency", lat, 1);
    chk("run_err", err_seen, 0);
    chk("run_run_r", run_all, 1);

    // Async reset mid-PULSE
    @(negedge clk);
    cmd_op = 2'b01; cmd_island = 2'd1; cmd_row = 6'd2; cmd_col = 6'd2; cmd_pulse = 16'd20;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (11) @(posedge clk);
    #3;
    chk("midpulse_prog_before", prog_r, 1);
    reset = 1'b1;
    #1;
    chk("async_prog_r", prog_r, 0);
    chk("async_dec_en", dec_en, 0);
    chk("async_vtun_en", vtun_en, 0);
    #12 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", cmd_ready, 1);
    chk("post_rst_run_r", run_r, 1);
    chk("post_rst_island_sel", island_sel, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
